// File: rtl/instr_trace_buffer.sv
// instr_trace_buffer: circular trace of retired (PC, instruction) pairs with a PC-match trigger that freezes capture after POST_TRIG further entries; entries are read back oldest-first by index with one cycle of latency.
// Ports: iCLK/iRST_n (sync, active low); iValid/iPC/iInstr retire strobe and entry; iTrigEn/iTrigPC trigger;
// iRearm clears and restarts capture; iRdIdx -> oRdPC/oRdInstr (registered); oCount, oWrapped, oState (00 CAPTURE, 01 POST, 10 HALTED).
// Define TRACE_WB_EN to add iWB/oRdWB, which widens each entry to 96 bits with the write-back value.
module instr_trace_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int POST_TRIG  = 8
) (
  input  logic                  iCLK,
  input  logic                  iRST_n,
  input  logic                  iValid,
  input  logic [31:0]           iPC,
  input  logic [31:0]           iInstr,
  input  logic                  iTrigEn,
  input  logic [31:0]           iTrigPC,
  input  logic                  iRearm,
  input  logic [DEPTH_LOG2-1:0] iRdIdx,
`ifdef TRACE_WB_EN
  input  logic [31:0]           iWB,
  output logic [31:0]           oRdWB,
`endif
  output logic [31:0]           oRdPC,
  output logic [31:0]           oRdInstr,
  output logic [DEPTH_LOG2:0]   oCount,
  output logic                  oWrapped,
  output logic [1:0]            oState
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef TRACE_WB_EN
  localparam int EW = 96;
`else
  localparam int EW = 64;
`endif
  localparam logic [1:0] S_CAP  = 2'b00;
  localparam logic [1:0] S_POST = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;
  logic [EW-1:0]         r_mem [DEPTH];
  logic [EW-1:0]         r_rd;
  logic [1:0]            r_state;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_post;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_wrapped;
  logic [EW-1:0]         w_wdata;
  logic                  w_we;
  logic                  w_full;
  logic                  w_match;
  logic                  w_hit;
  logic [DEPTH_LOG2-1:0] w_addr;
`ifdef TRACE_WB_EN
  assign w_wdata = {iWB, iInstr, iPC};
  assign oRdWB   = r_rd[95:64];
`else
  assign w_wdata = {iInstr, iPC};
`endif
  assign w_full  = r_count[DEPTH_LOG2];
  assign w_we    = iRST_n && !iRearm && iValid && r_state != S_HALT;
  assign w_match = r_state == S_CAP && iTrigEn && iPC == iTrigPC;
  // once full, the oldest entry sits at the next slot to be overwritten
  assign w_addr  = (w_full ? r_wr_ptr : '0) + iRdIdx;
  assign w_hit   = {1'b0, iRdIdx} < r_count;
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      r_state   <= S_CAP;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
      r_post    <= '0;
    end else if (iRearm) begin
      r_state   <= S_CAP;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
      r_post    <= '0;
    end else if (w_we) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      r_count  <= w_full ? r_count : r_count + 1'b1;
      if (w_full) r_wrapped <= 1'b1;
      if (w_match) begin
        r_post  <= DEPTH_LOG2'(POST_TRIG);
        r_state <= POST_TRIG == 0 ? S_HALT : S_POST;
      end else if (r_state == S_POST) begin
        r_post <= r_post - 1'b1;
        if (r_post == DEPTH_LOG2'(1)) r_state <= S_HALT;
      end
    end
  end
  always_ff @(posedge iCLK) begin
    if (w_we) r_mem[r_wr_ptr] <= w_wdata;
  end
  always_ff @(posedge iCLK) begin
    r_rd <= (iRST_n && w_hit) ? r_mem[w_addr] : '0;
  end
  assign oRdPC    = r_rd[31:0];
  assign oRdInstr = r_rd[63:32];
  assign oCount   = r_count;
  assign oWrapped = r_wrapped;
  assign oState   = r_state;
endmodule

// File: tb/tb_instr_trace_buffer.sv
// tb_instr_trace_buffer: directed and random checks of instr_trace_buffer against a trace-list reference model.
module tb_instr_trace_buffer;
  localparam int DL = 4;
  localparam int D  = 16;
  localparam int PT = 8;
  typedef struct packed {
    logic [31:0] wb;
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  logic          iCLK = 1'b0;
  logic          iRST_n = 1'b0;
  logic          iValid = 1'b0;
  logic [31:0]   iPC = '0;
  logic [31:0]   iInstr = '0;
  logic          iTrigEn = 1'b0;
  logic [31:0]   iTrigPC = '0;
  logic          iRearm = 1'b0;
  logic [DL-1:0] iRdIdx = '0;
  logic [31:0]   iWB = '0;
  logic [31:0]   oRdPC;
  logic [31:0]   oRdInstr;
  logic [DL:0]   oCount;
  logic          oWrapped;
  logic [1:0]    oState;
`ifdef TRACE_WB_EN
  logic [31:0]   oRdWB;
`endif
  ent_t q[$];
  int   mst = 0;
  int   rem = 0;
  logic mwrapped = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  instr_trace_buffer #(.DEPTH_LOG2(DL), .POST_TRIG(PT)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iValid(iValid), .iPC(iPC), .iInstr(iInstr),
    .iTrigEn(iTrigEn), .iTrigPC(iTrigPC), .iRearm(iRearm), .iRdIdx(iRdIdx),
`ifdef TRACE_WB_EN
    .iWB(iWB), .oRdWB(oRdWB),
`endif
    .oRdPC(oRdPC), .oRdInstr(oRdInstr), .oCount(oCount), .oWrapped(oWrapped), .oState(oState)
  );
  always #5 iCLK = ~iCLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic model();
    if (!iRST_n || iRearm) begin
      q.delete();
      mst = 0;
      mwrapped = 1'b0;
    end else if (iValid && mst != 2) begin
`ifdef TRACE_WB_EN
      q.push_back('{iWB, iInstr, iPC});
`else
      q.push_back('{32'h0, iInstr, iPC});
`endif
      if (q.size() > D) begin
        void'(q.pop_front());
        mwrapped = 1'b1;
      end
      if (mst == 0 && iTrigEn && iPC == iTrigPC) begin
        rem = PT;
        mst = PT == 0 ? 2 : 1;
      end else if (mst == 1) begin
        rem--;
        if (rem == 0) mst = 2;
      end
    end
  endtask
  task automatic cyc();
    ent_t e;
    int idx;
    idx = int'(iRdIdx);
    e = (iRST_n && idx < q.size()) ? q[idx] : '0;
    model();
    @(posedge iCLK);
    @(negedge iCLK);
    chk("rd_pc", oRdPC, e.pc);
    chk("rd_instr", oRdInstr, e.instr);
`ifdef TRACE_WB_EN
    chk("rd_wb", oRdWB, e.wb);
`endif
    chk("count", 32'(oCount), 32'(q.size()));
    chk("state", 32'(oState), 32'(mst));
    chk("wrapped", 32'(oWrapped), 32'(mwrapped));
  endtask
  task automatic strobe(input logic [31:0] pc, input logic [31:0] wb);
    iValid = 1'b1;
    iPC = pc;
    iInstr = $urandom;
    iWB = wb;
    cyc();
    iValid = 1'b0;
  endtask
  task automatic rd(input int idx);
    iRdIdx = DL'(idx);
    cyc();
  endtask
  task automatic rearm();
    iRearm = 1'b1;
    cyc();
    iRearm = 1'b0;
  endtask
  initial begin
    @(negedge iCLK);
    cyc();
    cyc();
    chk("rst_state", 32'(oState), 32'h0);
    chk("rst_count", 32'(oCount), 32'h0);
    chk("rst_wrapped", 32'(oWrapped), 32'h0);
    chk("rst_rdpc", oRdPC, 32'h0);
    iRST_n = 1'b1;
    for (int k = 0; k < 5; k++) strobe(32'h00400000 + 32'(4 * k), 32'h0);
    chk("t1_count", 32'(oCount), 32'd5);
    chk("t1_wrapped", 32'(oWrapped), 32'h0);
    chk("t1_state", 32'(oState), 32'h0);
    rd(0);
    chk("t1_rd0", oRdPC, 32'h00400000);
    rd(4);
    chk("t1_rd4", oRdPC, 32'h00400010);
    rd(5);
    chk("t1_rd5", oRdPC, 32'h0);
    rearm();
    for (int k = 0; k < 20; k++) strobe(32'h00400000 + 32'(4 * k), 32'h0);
    chk("t2_count", 32'(oCount), 32'd16);
    chk("t2_wrapped", 32'(oWrapped), 32'h1);
    rd(0);
    chk("t2_rd0", oRdPC, 32'h00400010);
    rd(15);
    chk("t2_rd15", oRdPC, 32'h0040004C);
    rearm();
    iTrigEn = 1'b1;
    iTrigPC = 32'h00400020;
    for (int k = 0; k < 30; k++) begin
      strobe(32'h00400000 + 32'(4 * k), 32'h0);
      if (k == 8) chk("t3_post", 32'(oState), 32'h1);
      if (k == 15) chk("t3_post_last", 32'(oState), 32'h1);
      if (k == 16) chk("t3_halt", 32'(oState), 32'h2);
    end
    chk("t3_state", 32'(oState), 32'h2);
    chk("t3_count", 32'(oCount), 32'd16);
    rd(15);
    chk("t3_rd15", oRdPC, 32'h00400040);
    iRearm = 1'b1;
    iValid = 1'b1;
    iPC = 32'h12345678;
    cyc();
    iRearm = 1'b0;
    iValid = 1'b0;
    chk("t4_count", 32'(oCount), 32'h0);
    chk("t4_state", 32'(oState), 32'h0);
    chk("t4_wrapped", 32'(oWrapped), 32'h0);
    strobe(32'h00400100, 32'h0);
    chk("t4_count1", 32'(oCount), 32'd1);
    rd(0);
    chk("t4_rd0", oRdPC, 32'h00400100);
    rearm();
    iTrigPC = 32'h00400008;
    for (int k = 0; k < 5; k++) strobe(32'h00400000 + 32'(4 * k), 32'h0);
    chk("t5_post", 32'(oState), 32'h1);
    rd(0);
    iRST_n = 1'b0;
    cyc();
    iRST_n = 1'b1;
    chk("t5_state", 32'(oState), 32'h0);
    chk("t5_count", 32'(oCount), 32'h0);
    chk("t5_rdpc", oRdPC, 32'h0);
`ifdef TRACE_WB_EN
    strobe(32'h00400000, 32'hA);
    strobe(32'h00400004, 32'hB);
    strobe(32'h00400008, 32'hC);
    rd(2);
    chk("t6_wb", oRdWB, 32'h0000000C);
`endif
    iTrigPC = 32'h00400024;
    for (int n = 0; n < 600; n++) begin
      iValid = 1'($urandom_range(0, 1));
      iPC = 32'h00400000 + 32'(4 * $urandom_range(0, 15));
      iInstr = $urandom;
      iWB = $urandom;
      iTrigEn = ($urandom % 4) != 0;
      iRearm = $urandom_range(0, 29) == 0;
      iRdIdx = DL'($urandom);
      cyc();
    end
    iValid = 1'b0;
    iRearm = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
